// File: rtl/r2sdf_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// r2sdf_seq_ctrl_pkg
// Shared constants and helpers for the 16-point R2SDF FFT sequencer.
//   - FFT geometry: point count, log2, stage count, datapath width.
//   - FSM state encoding.
//   - stage_offset(): enabled-cycle offset O_s of stage s relative to the input.
//   - stage_bf_bit(): butterfly/bypass select for stage s given the input count.
//   - bitrev4(): 4-bit bit reversal for output bin numbering.
// -----------------------------------------------------------------------------
package r2sdf_seq_ctrl_pkg;

  localparam int FFT_POINTS  = 16;
  localparam int LOG2_POINTS = 4;
  localparam int N_STAGES    = 4;
  localparam int DATA_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } seq_state_e;

  // O_0 = 0, O_s = O_{s-1} + L_{s-1}/2 + tw_ff, with L_s = 16 >> s (mod 16).
  function automatic logic [3:0] stage_offset(input int stage, input int tw_ff);
    int o;
    o = 0;
    for (int i = 0; i < stage; i++) begin
      o = o + ((FFT_POINTS >> i) / 2) + tw_ff;
    end
    return 4'(o);
  endfunction

  // Stage s sits in butterfly mode during the second half of its local block:
  // bit (3-s) of the local index k_s = (cnt - O_s) mod 16.
  function automatic logic stage_bf_bit(input logic [3:0] cnt, input int stage, input int tw_ff);
    logic [3:0] k;
    k = cnt - stage_offset(stage, tw_ff);
    return k[2'(3 - stage)];
  endfunction

  function automatic logic [3:0] bitrev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

endpackage

// File: rtl/r2sdf_tw_addr_gen.sv
// -----------------------------------------------------------------------------
// r2sdf_tw_addr_gen
// Twiddle ROM address for the multiplier following one R2SDF stage.
//   m    = (cnt + TW_FF - O_s - L_s/2) mod L_s
//   addr = (m < L_s/2) ? 0 : ((m - L_s/2) << STAGE) & 4'hF
// With TW_FF=1 the address leads the multiplier data by one cycle to cover
// the registered ROM.
// Ports:
//   cnt   in   4  input sample counter of the sequencer
//   addr  out  4  twiddle ROM address for this stage
// -----------------------------------------------------------------------------
module r2sdf_tw_addr_gen
  import r2sdf_seq_ctrl_pkg::*;
#(
  parameter int STAGE = 0,
  parameter int TW_FF = 1
) (
  input  logic [3:0] cnt,
  output logic [3:0] addr
);

  localparam int         L_LEN = FFT_POINTS >> STAGE;
  localparam logic [3:0] OFS   = stage_offset(STAGE, TW_FF);
  localparam logic [3:0] HALF  = 4'(L_LEN / 2);
  localparam logic [3:0] LMASK = 4'(L_LEN - 1);
  localparam logic [3:0] TWOFS = 4'(TW_FF);

  logic [3:0] m_s;

  // Position inside the stage block; first half multiplies by W^0.
  always_comb begin
    m_s = (cnt + TWOFS - OFS - HALF) & LMASK;
    if (m_s < HALF) begin
      addr = 4'd0;
    end else begin
      addr = (m_s - HALF) << STAGE;
    end
  end

endmodule

// File: rtl/r2sdf_seq_ctrl.sv
// -----------------------------------------------------------------------------
// r2sdf_seq_ctrl
// Sequencer for the 16-point radix-2 single-path delay-feedback FFT pipeline.
// Owns the input sample counter, the IDLE/RUN/FLUSH state, the zero-pad flush
// and the valid shift register that frames the output. All outputs are
// registered, so the datapath sees them one clock after the accepting cycle
// (it registers din once to line up).
// Configuration macro: R2SDF_SEQ_BITREV_EN -- when defined, dout_idx is the
// bit-reversed output counter (true bin number); otherwise the raw counter.
// Ports:
//   clk        in   1   clock
//   rst        in   1   synchronous active-high reset
//   din_valid  in   1   input sample valid
//   flush      in   1   zero-pad current frame and drain the pipeline
//   en         out  1   global pipeline advance
//   zero_in    out  1   datapath substitutes 0 for din
//   bf_sel     out  4   per-stage butterfly (1) / bypass-fill (0)
//   tw_addr    out  12  [4s+3:4s] twiddle ROM address after stage s (s=0..2)
//   dout_valid out  1   output sample valid
//   dout_sop   out  1   first bin of an output frame
//   dout_idx   out  4   frequency-bin index of current output
//   busy       out  1   sequencer not idle
// -----------------------------------------------------------------------------
module r2sdf_seq_ctrl
  import r2sdf_seq_ctrl_pkg::*;
#(
  parameter int TW_FF = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din_valid,
  input  logic        flush,
  output logic        en,
  output logic        zero_in,
  output logic [3:0]  bf_sel,
  output logic [11:0] tw_addr,
  output logic        dout_valid,
  output logic        dout_sop,
  output logic [3:0]  dout_idx,
  output logic        busy
);

  localparam int LAT = 15 + 3 * TW_FF;

  seq_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  ocnt_q, ocnt_d;
  logic [LAT-1:0] vsr_q, vsr_d;
  logic        pad_q, pad_d;

  logic        en_q, en_d;
  logic        zero_in_q, zero_in_d;
  logic [3:0]  bf_sel_q, bf_sel_d;
  logic [11:0] tw_addr_q, tw_addr_d;
  logic        dout_valid_q, dout_valid_d;
  logic        dout_sop_q, dout_sop_d;
  logic [3:0]  dout_idx_q, dout_idx_d;
  logic        busy_q, busy_d;

  logic        en_s;
  logic        take_s;
  logic        zero_s;
  logic        dv_s;
  logic [3:0]  idx_s;
  logic [3:0]  bf_s;
  logic [11:0] tw_s;

  for (genvar s = 0; s < N_STAGES; s++) begin : g_bf
    assign bf_s[s] = stage_bf_bit(cnt_q, s, TW_FF);
  end

  for (genvar s = 0; s < N_STAGES - 1; s++) begin : g_tw
    r2sdf_tw_addr_gen #(
      .STAGE (s),
      .TW_FF (TW_FF)
    ) u_tw (
      .cnt  (cnt_q),
      .addr (tw_s[4*s +: 4])
    );
  end

`ifdef R2SDF_SEQ_BITREV_EN
  assign idx_s = bitrev4(ocnt_q);
`else
  assign idx_s = ocnt_q;
`endif

  // Next state, counters, valid shift register and output decode.
  always_comb begin
    state_d = state_q;
    en_s    = 1'b0;
    take_s  = 1'b0;
    zero_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The wake-up sample is accepted; flush is ignored here.
        en_s   = din_valid;
        take_s = din_valid;
        if (din_valid) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        en_s   = din_valid;
        take_s = din_valid;
        if (flush) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // Padded zeros up to the frame end still count as frame samples.
        en_s   = 1'b1;
        take_s = pad_q;
        zero_s = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (en_s) begin
      cnt_d = cnt_q + 4'd1;
      vsr_d = {vsr_q[LAT-2:0], take_s};
    end else begin
      cnt_d = cnt_q;
      vsr_d = vsr_q;
    end

    dv_s = vsr_q[LAT-1] & en_s;
    if (dv_s) begin
      ocnt_d = ocnt_q + 4'd1;
    end else begin
      ocnt_d = ocnt_q;
    end

    // Padding runs from the flush point until the counter wraps.
    if ((state_q == ST_RUN) && flush) begin
      pad_d = (cnt_d != 4'd0);
    end else if (state_q == ST_FLUSH) begin
      pad_d = pad_q & (cnt_d != 4'd0);
    end else begin
      pad_d = 1'b0;
    end

    // Leave FLUSH on the cycle that empties the pipe with the counter at 0,
    // so the next frame starts at cnt == 0.
    if ((state_q == ST_FLUSH) && (vsr_d == '0) && (cnt_d == 4'd0)) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_d;
    end

    en_d         = en_s;
    zero_in_d    = zero_s;
    bf_sel_d     = en_s ? bf_s : bf_sel_q;
    tw_addr_d    = en_s ? tw_s : tw_addr_q;
    dout_valid_d = dv_s;
    dout_sop_d   = dv_s & (ocnt_q == 4'd0);
    dout_idx_d   = dv_s ? idx_s : dout_idx_q;
    busy_d       = (state_d != ST_IDLE);
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      ocnt_q       <= 4'd0;
      vsr_q        <= '0;
      pad_q        <= 1'b0;
      en_q         <= 1'b0;
      zero_in_q    <= 1'b0;
      bf_sel_q     <= 4'd0;
      tw_addr_q    <= 12'd0;
      dout_valid_q <= 1'b0;
      dout_sop_q   <= 1'b0;
      dout_idx_q   <= 4'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ocnt_q       <= ocnt_d;
      vsr_q        <= vsr_d;
      pad_q        <= pad_d;
      en_q         <= en_d;
      zero_in_q    <= zero_in_d;
      bf_sel_q     <= bf_sel_d;
      tw_addr_q    <= tw_addr_d;
      dout_valid_q <= dout_valid_d;
      dout_sop_q   <= dout_sop_d;
      dout_idx_q   <= dout_idx_d;
      busy_q       <= busy_d;
    end
  end

  assign en         = en_q;
  assign zero_in    = zero_in_q;
  assign bf_sel     = bf_sel_q;
  assign tw_addr    = tw_addr_q;
  assign dout_valid = dout_valid_q;
  assign dout_sop   = dout_sop_q;
  assign dout_idx   = dout_idx_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_r2sdf_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_r2sdf_seq_ctrl
// Self-checking bench for r2sdf_seq_ctrl (TW_FF=1, LAT=18). A behavioural
// model predicts each cycle's control outputs (pushed to a queue as stimulus
// is driven) and the expected output bins (pushed per frame sample, popped
// when they are due LAT enabled cycles later).
// -----------------------------------------------------------------------------
module tb_r2sdf_seq_ctrl;

  localparam int TW_FF = 1;
  localparam int LAT   = 15 + 3 * TW_FF;

  logic        clk;
  logic        rst;
  logic        din_valid;
  logic        flush;
  logic        en;
  logic        zero_in;
  logic [3:0]  bf_sel;
  logic [11:0] tw_addr;
  logic        dout_valid;
  logic        dout_sop;
  logic [3:0]  dout_idx;
  logic        busy;

  r2sdf_seq_ctrl #(.TW_FF(TW_FF)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .flush      (flush),
    .en         (en),
    .zero_in    (zero_in),
    .bf_sel     (bf_sel),
    .tw_addr    (tw_addr),
    .dout_valid (dout_valid),
    .dout_sop   (dout_sop),
    .dout_idx   (dout_idx),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int k;
    int en_n;
  } dout_rec_t;

  typedef struct {
    logic        is_rst;
    logic        en;
    logic        zero_in;
    logic        busy;
    logic [3:0]  bf;
    logic [11:0] tw;
  } ctl_rec_t;

  dout_rec_t dq[$];
  ctl_rec_t  cq[$];

  int   m_st;     // 0 idle, 1 run, 2 flush
  int   m_cnt;
  logic m_pad;
  int   m_en_n;
  int   m_push;
  int   n_seen;
  int   n_sop;

  function automatic int exp_ofs(input int s);
    int o;
    o = 0;
    for (int i = 0; i < s; i++) o = o + (16 >> i) / 2 + TW_FF;
    return o;
  endfunction

  function automatic logic [3:0] exp_bf(input int cnt);
    logic [3:0] b;
    int k;
    b = 4'd0;
    for (int s = 0; s < 4; s++) begin
      k = (cnt - exp_ofs(s) + 64) % 16;
      b[s] = ((k >> (3 - s)) & 1) != 0;
    end
    return b;
  endfunction

  function automatic logic [11:0] exp_tw(input int cnt);
    logic [11:0] t;
    int l;
    int m;
    int a;
    t = 12'd0;
    for (int s = 0; s < 3; s++) begin
      l = 16 >> s;
      m = (cnt + TW_FF - exp_ofs(s) - l / 2 + 64) % l;
      a = (m < l / 2) ? 0 : (((m - l / 2) << s) & 15);
      t[4*s +: 4] = 4'(a);
    end
    return t;
  endfunction

  function automatic logic [3:0] exp_idx(input int k);
    logic [3:0] v;
    logic [3:0] r;
    v = 4'(k);
`ifdef R2SDF_SEQ_BITREV_EN
    for (int i = 0; i < 4; i++) r[i] = v[3 - i];
`else
    r = v;
`endif
    return r;
  endfunction

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input logic dv, input logic fl, input logic r);
    ctl_rec_t  e;
    dout_rec_t exp_rec;
    dout_rec_t nr;
    logic      exp_dv;
    logic      take;
    e       = '{default: '0};
    exp_rec = '{default: 0};
    exp_dv  = 1'b0;
    take    = 1'b0;
    din_valid = dv;
    flush     = fl;
    rst       = r;
    if (r) begin
      m_st   = 0;
      m_cnt  = 0;
      m_pad  = 1'b0;
      m_push = 0;
      dq.delete();
      e.is_rst = 1'b1;
    end else begin
      case (m_st)
        0:       begin e.en = dv; take = dv; end
        1:       begin e.en = dv; take = dv; end
        default: begin e.en = 1'b1; e.zero_in = 1'b1; take = m_pad; end
      endcase
      if (e.en) begin
        e.bf = exp_bf(m_cnt);
        e.tw = exp_tw(m_cnt);
        if (dq.size() > 0 && dq[0].en_n + LAT == m_en_n) begin
          exp_dv  = 1'b1;
          exp_rec = dq.pop_front();
        end
        if (take) begin
          nr.k    = m_push % 16;
          nr.en_n = m_en_n;
          dq.push_back(nr);
          m_push++;
        end
        m_en_n++;
        m_cnt = (m_cnt + 1) % 16;
      end
      case (m_st)
        0: if (dv) m_st = 1;
        1: if (fl) begin m_st = 2; m_pad = (m_cnt != 0); end
        default: begin
          if (m_cnt == 0) m_pad = 1'b0;
          if (dq.size() == 0 && m_cnt == 0) m_st = 0;
        end
      endcase
      e.busy = (m_st != 0);
    end
    cq.push_back(e);

    @(posedge clk);
    #1;
    e = cq.pop_front();
    check_eq("en", en, e.en);
    check_eq("zero_in", zero_in, e.zero_in);
    check_eq("busy", busy, e.busy);
    check_eq("dout_valid", dout_valid, exp_dv);
    if (e.is_rst) begin
      check_eq("rst_bf_sel", bf_sel, 4'd0);
      check_eq("rst_tw_addr", tw_addr, 12'd0);
      check_eq("rst_dout_sop", dout_sop, 1'b0);
      check_eq("rst_dout_idx", dout_idx, 4'd0);
    end else if (e.en) begin
      check_eq("bf_sel", bf_sel, e.bf);
      check_eq("tw_addr", tw_addr, e.tw);
    end
    if (exp_dv) begin
      check_eq("dout_idx", dout_idx, exp_idx(exp_rec.k));
      check_eq("dout_sop", dout_sop, exp_rec.k == 0);
    end
    if (dout_valid) n_seen++;
    if (dout_valid && dout_sop) n_sop++;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && m_st != 0; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; din_valid = 1'b0; flush = 1'b0;
    m_st = 0; m_cnt = 0; m_pad = 1'b0; m_en_n = 0; m_push = 0;
    n_seen = 0; n_sop = 0;

    // Reset state.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);   // flush in IDLE is ignored
    step(1'b0, 1'b0, 1'b0);

    // 1: one frame back-to-back, then flush.
    n_seen = 0; n_sop = 0;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    drain();
    check_eq("t1_dout_count", n_seen, 16);
    check_eq("t1_sop_count", n_sop, 1);

    // 2: continuous 48 samples.
    n_seen = 0; n_sop = 0;
    for (int i = 0; i < 48; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    drain();
    check_eq("t2_dout_count", n_seen, 48);
    check_eq("t2_sop_count", n_sop, 3);

    // 3: gaps of 3 cycles every 5, 32 samples; flush with the last sample.
    n_seen = 0; n_sop = 0;
    begin
      int acc;
      acc = 0;
      for (int i = 0; i < 200 && acc < 32; i++) begin
        if ((i % 5) < 2) begin
          acc++;
          step(1'b1, acc == 32, 1'b0);
        end else begin
          step(1'b0, 1'b0, 1'b0);
        end
      end
    end
    drain();
    check_eq("t3_dout_count", n_seen, 32);
    check_eq("t3_sop_count", n_sop, 2);

    // 4: flush at cnt=5, zero-pad to the frame end.
    n_seen = 0; n_sop = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    drain();
    check_eq("t4_dout_count", n_seen, 16);
    check_eq("t4_sop_count", n_sop, 1);

    // 5: reset mid-frame at cnt=9, then a clean frame.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    n_seen = 0; n_sop = 0;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    drain();
    check_eq("t5_dout_count", n_seen, 16);
    check_eq("t5_sop_count", n_sop, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
